// File: rtl/alu_result_checker_if.sv
// Sample stream carrying ALU operands, control and the result under test.
// The producer drives the sample and in_valid; the checker returns in_ready.
interface alu_result_checker_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  func_code;
    logic [6:0]  opcode;
    logic [31:0] alu_out;

    modport master (
        output in_valid, a, b, func_code, opcode, alu_out,
        input  in_ready
    );

    modport slave (
        input  in_valid, a, b, func_code, opcode, alu_out,
        output in_ready
    );
endinterface

// File: rtl/alu_result_checker.sv
// Consumes ALU samples, recomputes the RV32I R-type result and keeps
// pass/fail/skip counters plus a record of the first mismatch in each run.
//
// state | meaning
// IDLE  | waiting for start, not accepting samples
// RUN   | accepting samples until NUM_VECTORS have been taken
// DRAIN | last sample's compare is still in stage 2
// DONE  | results final; done/pass asserted until the next start
module alu_result_checker #(
    parameter int NUM_VECTORS = 9,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    alu_result_checker_if.slave  smp,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     skip_count,
    output logic [CNT_W-1:0]     first_fail_idx,
    output logic [31:0]          first_fail_exp,
    output logic [31:0]          first_fail_act,
    output logic                 done,
    output logic                 pass
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [6:0]       OP_RTYPE = 7'b0110011;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_t state_q, state_d;

    logic [CNT_W-1:0] accept_count;
    logic             accept;

    logic             s1_valid;
    logic [31:0]      s1_a, s1_b, s1_out;
    logic [3:0]       s1_func;
    logic [6:0]       s1_op;
    logic [CNT_W-1:0] s1_idx;

    logic [31:0]      exp_val;
    logic             checkable;
    logic [4:0]       shamt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // A start pulse takes priority over a sample offered in the same cycle.
    assign smp.in_ready = (state_q == S_RUN);
    assign accept       = smp.in_valid & smp.in_ready & ~start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (start) state_d = S_RUN;
                     else if (accept && accept_count == LAST_IDX) state_d = S_DRAIN;
            S_DRAIN: state_d = start ? S_RUN : S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        exp_val   = '0;
        checkable = (s1_op == OP_RTYPE);
        shamt     = s1_b[4:0];
        unique case (s1_func)
            4'b0000: exp_val = s1_a + s1_b;
            4'b1000: exp_val = s1_a - s1_b;
            4'b0001: exp_val = s1_a << shamt;
            4'b0010: exp_val = {31'd0, $signed(s1_a) < $signed(s1_b)};
            4'b0011: exp_val = {31'd0, s1_a < s1_b};
            4'b0100: exp_val = s1_a ^ s1_b;
            4'b0101: exp_val = s1_a >> shamt;
            4'b1101: exp_val = $signed(s1_a) >>> shamt;
            4'b0110: exp_val = s1_a | s1_b;
            4'b0111: exp_val = s1_a & s1_b;
            default: checkable = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_count   <= '0;
            s1_valid       <= 1'b0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_out         <= '0;
            s1_func        <= '0;
            s1_op          <= '0;
            s1_idx         <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            skip_count     <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_act <= '0;
        end else if (start) begin
            accept_count   <= '0;
            s1_valid       <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            skip_count     <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_act <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a         <= smp.a;
                s1_b         <= smp.b;
                s1_out       <= smp.alu_out;
                s1_func      <= smp.func_code;
                s1_op        <= smp.opcode;
                s1_idx       <= accept_count;
                accept_count <= sat_inc(accept_count);
            end
            if (s1_valid) begin
                if (!checkable) begin
                    skip_count <= sat_inc(skip_count);
                end else if (exp_val == s1_out) begin
                    pass_count <= sat_inc(pass_count);
                end else begin
                    // fail_count only leaves zero on the first mismatch of a run
                    if (fail_count == '0) begin
                        first_fail_idx <= s1_idx;
                        first_fail_exp <= exp_val;
                        first_fail_act <= s1_out;
                    end
                    fail_count <= sat_inc(fail_count);
                end
            end
        end
    end

    // Registered one cycle behind DONE so pass sees the final fail_count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= (state_q == S_DONE) && !start;
            pass <= (state_q == S_DONE) && !start && (fail_count == '0);
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed and randomized runs of alu_result_checker against a behavioural
// model of the RV32I R-type ALU and the run bookkeeping.
module tb_alu_result_checker;

    localparam int NV = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pass_count, fail_count, skip_count, first_fail_idx;
    logic [31:0] first_fail_exp, first_fail_act;
    logic        done, pass;

    int errors = 0;
    int checks = 0;

    int          m_pass, m_fail, m_skip, m_idx;
    logic [31:0] m_ff_idx, m_ff_exp, m_ff_act;

    alu_result_checker_if bus ();

    alu_result_checker #(.NUM_VECTORS(NV), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .smp            (bus.slave),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .skip_count     (skip_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_exp (first_fail_exp),
        .first_fail_act (first_fail_act),
        .done           (done),
        .pass           (pass)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {checkable, value}.
    function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] fc, input logic [6:0] op);
        int unsigned sh;
        int          sa, sb;
        logic [31:0] ones;
        sh   = b % 32;
        sa   = a;
        sb   = b;
        ones = 32'hFFFF_FFFF;
        if (op != 7'h33) return {1'b0, 32'h0};
        case (fc)
            4'h0: return {1'b1, a + b};
            4'h8: return {1'b1, a - b};
            4'h1: return {1'b1, a << sh};
            4'h2: return {1'b1, (sa < sb) ? 32'd1 : 32'd0};
            4'h3: return {1'b1, (a < b) ? 32'd1 : 32'd0};
            4'h4: return {1'b1, a ^ b};
            4'h5: return {1'b1, a >> sh};
            4'hD: return {1'b1, (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0)};
            4'h6: return {1'b1, a | b};
            4'h7: return {1'b1, a & b};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_skip = 0; m_idx = 0;
        m_ff_idx = 0; m_ff_exp = 0; m_ff_act = 0;
    endtask

    task automatic model_accept(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] fc, input logic [6:0] op, input logic [31:0] out);
        logic [32:0] g;
        g = golden(a, b, fc, op);
        if (!g[32]) m_skip++;
        else if (g[31:0] == out) m_pass++;
        else begin
            if (m_fail == 0) begin
                m_ff_idx = m_idx; m_ff_exp = g[31:0]; m_ff_act = out;
            end
            m_fail++;
        end
        m_idx++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] fc, input logic [6:0] op, input logic [31:0] out);
        int w = 0;
        bus.a = a; bus.b = b; bus.func_code = fc; bus.opcode = op; bus.alu_out = out;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) check("ready_timeout", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        model_accept(a, b, fc, op, out);
    endtask

    task automatic send_ok(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fc);
        logic [32:0] g;
        g = golden(a, b, fc, 7'h33);
        send(a, b, fc, 7'h33, g[31:0]);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pass_count"}, pass_count, m_pass);
        check({tag, "_fail_count"}, fail_count, m_fail);
        check({tag, "_skip_count"}, skip_count, m_skip);
        check({tag, "_ff_idx"}, first_fail_idx, m_ff_idx);
        check({tag, "_ff_exp"}, first_fail_exp, m_ff_exp);
        check({tag, "_ff_act"}, first_fail_act, m_ff_act);
    endtask

    // Called right after the final acceptance edge k.
    task automatic finish_run(input string tag);
        check({tag, "_ready_drain"}, bus.in_ready, 0);
        check({tag, "_done_k"}, done, 0);
        tick();
        check({tag, "_done_k1"}, done, 0);
        check_counts(tag);
        tick();
        check({tag, "_done_k2"}, done, 1);
        check({tag, "_pass"}, pass, (m_fail == 0) ? 1 : 0);
        check({tag, "_ready_done"}, bus.in_ready, 0);
    endtask

    task automatic directed_run(input logic [31:0] add_out, input logic [31:0] xor_out);
        send(32'h0F, 32'h55, 4'h7, 7'h33, 32'h05);
        send(32'h0F, 32'h55, 4'h6, 7'h33, 32'h5F);
        send(32'd10000, 32'd111, 4'h0, 7'h33, add_out);
        send(32'd10000, 32'd111, 4'h8, 7'h33, 32'd9889);
        send(32'd0, 32'd2, 4'h2, 7'h33, 32'd1);
        send(32'h10, 32'd2, 4'h5, 7'h33, 32'h4);
        send(32'h8000_0000, 32'd1, 4'hD, 7'h33, 32'hC000_0000);
        send(32'd2, 32'd2, 4'h1, 7'h33, 32'd8);
        send(32'h55, 32'hFF, 4'h4, 7'h33, xor_out);
    endtask

    initial begin
        logic [31:0] ra, rb, ro;
        logic [3:0]  rf;
        logic [6:0]  rop;
        logic [32:0] g;
        logic [3:0]  fc_list [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};

        reset = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        bus.func_code = '0; bus.opcode = '0; bus.alu_out = '0;
        model_clear();
        repeat (2) tick();
        check("rst_ready", bus.in_ready, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check_counts("rst");
        reset = 1'b0;
        tick();
        check("idle_ready", bus.in_ready, 0);

        // All-correct directed run
        pulse_start();
        check("run_ready", bus.in_ready, 1);
        directed_run(32'd10111, 32'hAA);
        finish_run("dir_ok");
        check("dir_ok_pass_count9", pass_count, 9);
        tick();
        check("done_held", done, 1);

        // Two wrong results: ADD at index 2 and XOR at index 8
        pulse_start();
        check("restart_clear_pass", pass_count, 0);
        check("restart_done_low", done, 0);
        directed_run(32'd10110, 32'hAB);
        finish_run("dir_fail");
        check("dir_fail_idx2", first_fail_idx, 2);
        check("dir_fail_exp", first_fail_exp, 32'd10111);

        // Skip cases among correct samples
        pulse_start();
        send_ok(32'd5, 32'd7, 4'h0);
        send(32'd5, 32'd7, 4'h0, 7'h00, 32'd12);
        send_ok(32'hF0F0, 32'h0FF0, 4'h7);
        send(32'd5, 32'd7, 4'h9, 7'h33, 32'd0);
        for (int i = 0; i < 5; i++) send_ok($urandom, $urandom, fc_list[$urandom_range(9, 0)]);
        finish_run("skip");
        check("skip_two", skip_count, 2);

        // Randomized run, in_valid toggled every other cycle
        pulse_start();
        for (int i = 0; i < NV; i++) begin
            ra = $urandom; rb = $urandom;
            rf = ($urandom_range(7, 0) == 0) ? 4'($urandom) : fc_list[$urandom_range(9, 0)];
            rop = ($urandom_range(7, 0) == 0) ? 7'($urandom) : 7'h33;
            g = golden(ra, rb, rf, rop);
            ro = ($urandom_range(3, 0) == 0) ? (g[31:0] ^ (32'd1 << $urandom_range(31, 0))) : g[31:0];
            send(ra, rb, rf, rop, ro);
            if (i != NV - 1) begin
                bus.a = $urandom; bus.alu_out = $urandom;
                tick();
            end
        end
        finish_run("rand");

        // Asynchronous reset after 4 samples
        pulse_start();
        for (int i = 0; i < 4; i++) send_ok($urandom, $urandom, fc_list[$urandom_range(9, 0)]);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check_counts("mid_rst");
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("post_rst_ready", bus.in_ready, 0);
        check("post_rst_pass_count", pass_count, 0);

        // start pulsed mid-run with a sample offered in the same cycle
        pulse_start();
        for (int i = 0; i < 5; i++) send_ok($urandom, $urandom, fc_list[$urandom_range(9, 0)]);
        bus.in_valid = 1'b1;
        pulse_start();
        bus.in_valid = 1'b0;
        tick();
        check_counts("restart");
        check("restart_ready", bus.in_ready, 1);
        for (int i = 0; i < NV - 1; i++) send_ok($urandom, $urandom, fc_list[$urandom_range(9, 0)]);
        tick();
        tick();
        check("restart_not_done_8", done, 0);
        check("restart_still_ready", bus.in_ready, 1);
        send_ok($urandom, $urandom, 4'h0);
        finish_run("restart_full");
        check("restart_pass_count9", pass_count, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Self-checking consumer for the ALU datapath: accepts a stream of ALU operand/control/result samples over a valid/ready handshake, recomputes the expected RV32I R-type result with an internal golden model, and keeps pass/fail/skip counters plus a record of the first mismatch. Sits downstream of the ALUControl/alu pair in simulation and FPGA bring-up harnesses, the receiving end of the stimulus that drives those blocks.

## Interface
- NUM_VECTORS, 9, samples accepted per run before the run ends
- CNT_W, 16, width of all counters and the sample index
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: clear results, begin a run
- in_valid  in  1  sample present
- in_ready  out  1  checker can accept a sample
- a  in  32  ALU operand A
- b  in  32  ALU operand B
- func_code  in  4  {instr[30], funct3}
- opcode  in  7  instr[6:0]
- alu_out  in  32  result produced by the ALU under test
- pass_count  out  CNT_W  matching samples
- fail_count  out  CNT_W  mismatching samples
- skip_count  out  CNT_W  samples not checkable
- first_fail_idx  out  CNT_W  index (0-based) of first mismatch
- first_fail_exp  out  32  expected value at first mismatch
- first_fail_act  out  32  alu_out at first mismatch
- done  out  1  run complete, held until next start
- pass  out  1  done and fail_count == 0

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE: in_ready = 0; start → RUN, all counters/records cleared.
- RUN: in_ready = 1; sample accepted when in_valid & in_ready. Accept counter increments per acceptance; on the acceptance making it NUM_VECTORS → DRAIN.
- DRAIN: in_ready = 0; one cycle for last compare to land → DONE.
- DONE: done = 1, pass = (fail_count == 0); start → RUN with clearing.
- start in RUN/DRAIN: restart; results cleared, any in-flight compare discarded, sample offered in the start cycle is not accepted.
- Stage 1 (acceptance edge): register a, b, func_code, opcode, alu_out, sample index.
- Stage 2 (next edge): compute expected, update exactly one counter.
- Golden model, only when opcode == 7'b0110011: 0000 ADD a+b mod 2^32; 1000 SUB a−b mod 2^32; 0001 SLL a<<b[4:0]; 0010 SLT signed a<b → 1/0; 0011 SLTU unsigned; 0100 XOR; 0101 SRL logical by b[4:0]; 1101 SRA arithmetic by b[4:0]; 0110 OR; 0111 AND. Any other func_code or opcode → skip_count++.
- Mismatch: fail_count++; if first fail of run, latch idx/exp/act. Later fails do not overwrite.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset values: in_ready 0, done 0, pass 0, all counters 0, first_fail_* 0.
- Reset mid-run: immediate return to IDLE, all outputs to reset values, in-flight sample dropped.
- Counter update latency: 1 cycle after acceptance edge (visible after edge k+1 for sample accepted at edge k).
- Throughput: one sample per cycle in RUN.
- done rises on edge k+2 after final acceptance at edge k; pass valid same cycle as done.
- in_ready is registered from state only, never from in_valid.

## Test plan
- Reset, start, 9 samples back-to-back incl. AND 0x0F&0x55 (alu_out 0x05), OR (0x5F), ADD 10000+111 (10111), SUB (9889), SLT 0<2 (1), SRL 0x10>>2 (0x4), SRA 0x80000000>>1 (0xC0000000), SLL 2<<2 (8), XOR 0x55^0xFF (0xAA) → pass_count 9, done 2 cycles after last accept, pass 1.
- Same run with ADD sample index 2 alu_out 10110 and XOR index 8 wrong → fail_count 2, first_fail_idx 2, exp 10111, act 10110, pass 0.
- Opcode 0000000 and func_code 1001 samples → skip_count 2, no fail.
- in_valid toggled every other cycle → only handshaked samples counted; done after 9th acceptance.
- reset asserted mid-run after 4 samples → all outputs zero same cycle, IDLE, in_ready 0.
- start pulsed in RUN after 5 samples → counters cleared, new run needs 9 more accepts.
